// File: rtl/sram_mask_pkg.sv
// Shared types and helpers for the masked two-port SRAM.
//   sram_state_e : controller state (StInit clears the array, StIdle serves requests)
//   calc_depth   : number of words for a given address width
//   lane_width   : bits per write lane
package sram_mask_pkg;

  typedef enum logic [0:0] {
    StInit = 1'b0,
    StIdle = 1'b1
  } sram_state_e;

  function automatic int unsigned calc_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic int unsigned lane_width(input int unsigned data_width,
                                             input int unsigned mask_width);
    return data_width / mask_width;
  endfunction

  localparam int unsigned DEFAULT_ADDR_WIDTH = 10;
  localparam int unsigned DEFAULT_DEPTH      = calc_depth(DEFAULT_ADDR_WIDTH);

endpackage

// File: rtl/sram_mask_lane_merge.sv
// Combinational lane merge: each lane whose mask bit is set takes new_word, the
// others keep old_word. Shared by the array write path and the write-to-read bypass.
//   old_word : current array contents
//   new_word : incoming write data
//   mask     : one bit per lane, bit i covers [i*LW +: LW]
//   merged   : resulting word
module sram_mask_lane_merge
  import sram_mask_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned WMASK_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]  old_word,
  input  logic [DATA_WIDTH-1:0]  new_word,
  input  logic [WMASK_WIDTH-1:0] mask,
  output logic [DATA_WIDTH-1:0]  merged
);

  localparam int unsigned LW = lane_width(DATA_WIDTH, WMASK_WIDTH);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < WMASK_WIDTH; i++) begin
      if (mask[i]) begin
        merged[i*LW +: LW] = new_word[i*LW +: LW];
      end
    end
  end

endmodule

// File: rtl/sram_mask_2p.sv
// Two-port (1W/1R) synchronous SRAM with per-lane write masking, a self-clearing
// sequence after reset and a 1- or 2-stage read pipeline.
//   clk    : rising-edge clock
//   rstb   : asynchronous active-low reset
//   ready  : high once the clear sequence has finished
//   wce    : write enable; waddr/wmask/wdata give address, lane mask, data
//   rce    : read enable; raddr gives address
//   rdata  : read data, holds its value between completed reads
//   rvalid : one-cycle pulse per completed read
// Build option: define SRAM_MASK_BYPASS_EN to make a same-cycle, same-address
// read return the merged (write-first) word instead of the old word.
module sram_mask_2p
  import sram_mask_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned WMASK_WIDTH  = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rstb,
  output logic                   ready,
  input  logic                   wce,
  input  logic [ADDR_WIDTH-1:0]  waddr,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic                   rce,
  input  logic [ADDR_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0]  rdata,
  output logic                   rvalid
);

  localparam int unsigned DEPTH = calc_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // Controller: walk every address once, then serve requests.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready = (state_q == StIdle);

  logic wr_acc, rd_acc;
  assign wr_acc = wce & ready;
  assign rd_acc = rce & ready;

  // Storage array: no reset, the clear sequence provides the initial contents.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word;

  sram_mask_lane_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .WMASK_WIDTH(WMASK_WIDTH)
  ) u_merge (
    .old_word(mem_q[waddr]),
    .new_word(wdata),
    .mask    (wmask),
    .merged  (wr_merged)
  );

  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc) begin
      mem_q[waddr] <= wr_merged;
    end
  end

`ifdef SRAM_MASK_BYPASS_EN
  // Write-first: a colliding read sees the merged word being written this edge.
  assign rd_word = (wr_acc && (waddr == raddr)) ? wr_merged : mem_q[raddr];
`else
  // Read-first: the array read happens before this edge's write lands.
  assign rd_word = mem_q[raddr];
`endif

  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q;

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
        rvalid_q   <= 1'b0;
        rdata_q    <= '0;
      end else begin
        s1_valid_q <= rd_acc;
        if (rd_acc) begin
          s1_data_q <= rd_word;
        end
        rvalid_q <= s1_valid_q;
        if (s1_valid_q) begin
          rdata_q <= s1_data_q;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) begin
          rdata_q <= rd_word;
        end
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_sram_mask_2p.sv
// Directed bench for sram_mask_2p: a latency-1 and a latency-2 instance (16 words,
// 8 lanes of 8 bits) share every input; each output set is checked against
// hand-computed values.
module tb_sram_mask_2p;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 4;
  localparam int unsigned MW = 8;

  logic          clk = 1'b0;
  logic          rstb;
  logic          wce, rce;
  logic [AW-1:0] waddr, raddr;
  logic [MW-1:0] wmask;
  logic [DW-1:0] wdata;
  logic          ready1, ready2, rvalid1, rvalid2;
  logic [DW-1:0] rdata1, rdata2;

  always #5 clk = ~clk;

  sram_mask_2p #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .READ_LATENCY(1)
  ) u_lat1 (
    .clk(clk), .rstb(rstb), .ready(ready1),
    .wce(wce), .waddr(waddr), .wmask(wmask), .wdata(wdata),
    .rce(rce), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1)
  );

  sram_mask_2p #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .READ_LATENCY(2)
  ) u_lat2 (
    .clk(clk), .rstb(rstb), .ready(ready2),
    .wce(wce), .waddr(waddr), .wmask(wmask), .wdata(wdata),
    .rce(rce), .raddr(raddr), .rdata(rdata2), .rvalid(rvalid2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] rd_addr [16];
  logic [DW-1:0] rd_exp  [16];

  task automatic check_eq(input string tag, input logic [DW-1:0] got,
                          input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [MW-1:0] m);
    wce = 1'b1; waddr = a; wdata = d; wmask = m;
    tick();
    wce = 1'b0;
  endtask

  // Count edges until ready (bounded), tallying any rvalid seen on the way.
  task automatic wait_ready(output int cyc, output int stray);
    cyc = 0;
    stray = 0;
    while (!ready1 && cyc < 100) begin
      tick();
      cyc++;
      if (rvalid1 || rvalid2) stray++;
    end
  endtask

  // Back-to-back reads of rd_addr[0..n-1]; a wce set up by the caller applies
  // to the first read cycle only.
  task automatic read_burst(input int n);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        rce = 1'b1; raddr = rd_addr[i];
      end else begin
        rce = 1'b0;
      end
      tick();
      wce = 1'b0;
      if (i < n) begin
        check_eq("l1_rvalid", {63'd0, rvalid1}, 64'd1);
        check_eq("l1_rdata", rdata1, rd_exp[i]);
      end else begin
        check_eq("l1_rvalid_end", {63'd0, rvalid1}, 64'd0);
      end
      if (i >= 1) begin
        check_eq("l2_rvalid", {63'd0, rvalid2}, 64'd1);
        check_eq("l2_rdata", rdata2, rd_exp[i-1]);
      end else begin
        check_eq("l2_rvalid_first", {63'd0, rvalid2}, 64'd0);
      end
    end
    tick();
    check_eq("l2_rvalid_end", {63'd0, rvalid2}, 64'd0);
    check_eq("l1_rdata_hold", rdata1, rd_exp[n-1]);
    check_eq("l2_rdata_hold", rdata2, rd_exp[n-1]);
  endtask

  int cyc, stray;
  logic [DW-1:0] same_exp;

  initial begin
    rstb = 1'b0; wce = 1'b0; rce = 1'b0;
    waddr = '0; raddr = '0; wmask = '0; wdata = '0;
    tick(); tick();
    check_eq("rst_ready", {62'd0, ready1, ready2}, 64'd0);
    check_eq("rst_rvalid", {62'd0, rvalid1, rvalid2}, 64'd0);
    check_eq("rst_rdata1", rdata1, 64'd0);
    check_eq("rst_rdata2", rdata2, 64'd0);

    // Release reset with requests held during the clear; they must be ignored.
    rstb = 1'b1;
    wce = 1'b1; waddr = 4'd9; wdata = '1; wmask = 8'hFF;
    rce = 1'b1; raddr = 4'd9;
    wait_ready(cyc, stray);
    wce = 1'b0; rce = 1'b0;
    check_eq("clear_cycles", 64'(cyc), 64'd16);
    check_eq("init_stray_rvalid", 64'(stray), 64'd0);
    check_eq("ready2", {63'd0, ready2}, 64'd1);

    // Every address reads zero after the clear.
    for (int i = 0; i < 16; i++) begin
      rd_addr[i] = 4'(i);
      rd_exp[i]  = 64'd0;
    end
    read_burst(16);

    // Masked writes, including a lane subset and an all-zero mask.
    write_word(4'd0, 64'h0123456789ABCDEF, 8'hFF);
    write_word(4'd1, 64'hFEDCBA9876543210, 8'hFF);
    write_word(4'd1, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    write_word(4'd2, 64'h5A5A5A5AA5A5A5A5, 8'h3C);
    write_word(4'd5, 64'hDEADBEEFCAFEBABE, 8'hFF);
    write_word(4'd5, 64'h1111111111111111, 8'h0F);
    rd_addr[0] = 4'd0; rd_exp[0] = 64'h0123456789ABCDEF;
    rd_addr[1] = 4'd1; rd_exp[1] = 64'hFEDCBA9876543210;
    rd_addr[2] = 4'd2; rd_exp[2] = 64'h00005A5AA5A50000;
    rd_addr[3] = 4'd5; rd_exp[3] = 64'hDEADBEEF11111111;
    read_burst(4);

    // Same-cycle, same-address collision on addr 3 (previously zero).
`ifdef SRAM_MASK_BYPASS_EN
    same_exp = 64'hAAAAAAAA00000000;
`else
    same_exp = 64'h0000000000000000;
`endif
    wce = 1'b1; waddr = 4'd3; wdata = 64'hAAAAAAAAAAAAAAAA; wmask = 8'hF0;
    rd_addr[0] = 4'd3; rd_exp[0] = same_exp;
    rd_addr[1] = 4'd3; rd_exp[1] = 64'hAAAAAAAA00000000;
    read_burst(2);

    // Same-cycle write and read to different addresses are independent.
    wce = 1'b1; waddr = 4'd7; wdata = 64'h7777777777777777; wmask = 8'hFF;
    rd_addr[0] = 4'd5; rd_exp[0] = 64'hDEADBEEF11111111;
    rd_addr[1] = 4'd7; rd_exp[1] = 64'h7777777777777777;
    read_burst(2);

    // Reset in IDLE: outputs clear asynchronously, before any edge.
    rstb = 1'b0;
    #1;
    check_eq("async_rdata1", rdata1, 64'd0);
    check_eq("async_ready", {62'd0, ready1, ready2}, 64'd0);
    tick();
    rstb = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check_eq("mid_init_ready", {63'd0, ready1}, 64'd0);
    // Second reset with the counter at 7: the clear must restart from 0.
    rstb = 1'b0;
    #1;
    check_eq("mid_init_rst_ready", {63'd0, ready1}, 64'd0);
    tick();
    rstb = 1'b1;
    wait_ready(cyc, stray);
    check_eq("restart_clear_cycles", 64'(cyc), 64'd16);
    check_eq("restart_stray_rvalid", 64'(stray), 64'd0);

    // Reset with a read in flight: nothing stale may emerge afterwards.
    write_word(4'd4, 64'h4444444444444444, 8'hFF);
    rce = 1'b1; raddr = 4'd4;
    tick();
    rce = 1'b0;
    check_eq("inflight_l1_rvalid", {63'd0, rvalid1}, 64'd1);
    check_eq("inflight_l1_rdata", rdata1, 64'h4444444444444444);
    rstb = 1'b0;
    #1;
    check_eq("flush_rvalid", {62'd0, rvalid1, rvalid2}, 64'd0);
    check_eq("flush_rdata1", rdata1, 64'd0);
    check_eq("flush_rdata2", rdata2, 64'd0);
    tick();
    rstb = 1'b1;
    wait_ready(cyc, stray);
    check_eq("flush_clear_cycles", 64'(cyc), 64'd16);
    check_eq("flush_stray_rvalid", 64'(stray), 64'd0);

    // Cleared again, including addr 9 targeted during the first clear.
    rd_addr[0] = 4'd4; rd_exp[0] = 64'd0;
    rd_addr[1] = 4'd9; rd_exp[1] = 64'd0;
    rd_addr[2] = 4'd5; rd_exp[2] = 64'd0;
    read_burst(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_mask_2p.md
# sram_mask_2p

Parametrised two-port (1W/1R) synchronous SRAM with per-lane write masking. After reset it runs a self-initialising clear sequence, and it has a configurable read pipeline. It generalises the team's fixed 1024x64, 8-lane masked macro model in width, depth and lane count, and adds a `ready` handshake, a `rvalid` qualifier and optional write-to-read bypass. It sits between cache/buffer controllers and the behavioural storage array.

## Interface
- `DATA_WIDTH`, 64, word width in bits; must be a multiple of `WMASK_WIDTH`.
- `ADDR_WIDTH`, 10, address bits; depth = 2^`ADDR_WIDTH`.
- `WMASK_WIDTH`, 8, number of write lanes; lane width = `DATA_WIDTH`/`WMASK_WIDTH`.
- `READ_LATENCY`, 1, either 1 or 2 cycles from read accept to data.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstb`  in  1  asynchronous, active-low reset.
- `ready`  out  1  high when the array accepts requests.
- `wce`  in  1  write enable.
- `waddr`  in  `ADDR_WIDTH`  write address.
- `wmask`  in  `WMASK_WIDTH`  bit i enables lane i (bits [i*LW +: LW]).
- `wdata`  in  `DATA_WIDTH`  write data.
- `rce`  in  1  read enable.
- `raddr`  in  `ADDR_WIDTH`  read address.
- `rdata`  out  `DATA_WIDTH`  read data.
- `rvalid`  out  1  `rdata` is valid this cycle.

## Operation
- FSM states: `INIT` and `IDLE`.
  - Reset enters `INIT` with the clear counter at 0.
  - `INIT` writes all-zero to address = counter every cycle and increments the counter.
  - After address 2^`ADDR_WIDTH`-1 is written, the FSM goes to `IDLE`.
- `ready` is 0 in `INIT` and 1 in `IDLE`.
- `wce`/`rce` asserted while `ready`=0 are ignored. No state change, no `rvalid`.
- Write (in `IDLE`, `wce`=1): lanes with `wmask` bit = 1 take `wdata`; other lanes keep their contents. `wmask`=0 is a legal no-op.
- Read (in `IDLE`, `rce`=1): returns the word at `raddr` after `READ_LATENCY` cycles, with `rvalid`=1 for exactly one cycle per accepted read.
- Back-to-back reads every cycle are supported, giving one result per cycle.
- `rdata` holds its last value when no read completes. `rvalid`=0 in that case.
- Read and write to different addresses in the same cycle are independent.
- Read and write to the same address in the same cycle: see Configuration.
- Address wrap: none. Each address is independent and the full depth is usable.
- Reset mid-operation (during `INIT` or `IDLE`):
  - Outputs return to reset values immediately.
  - The pipeline is flushed and pending reads are dropped.
  - `INIT` restarts at address 0.

## Timing
- Reset values: `ready`=0, `rvalid`=0, `rdata`=0. Internal: FSM=`INIT`, counter=0.
- Clear duration: exactly 2^`ADDR_WIDTH` cycles after `rstb` deasserts. `ready` rises on the edge that completes the last clear write.
- Write is committed at the rising edge where `wce`=1 and `ready`=1. A read accepted in the next cycle sees the new data.
- With `READ_LATENCY`=1: read sampled at edge N; `rdata`/`rvalid` update at edge N; `rdata` is usable in cycle N..N+1.
- With `READ_LATENCY`=2: one extra output register stage. `rvalid` is delayed by the same amount.

## Configuration
- Macro `SRAM_MASK_BYPASS_EN`.
- Defined: a same-cycle, same-address read returns the merged word. Enabled lanes come from `wdata`, other lanes are the old contents (write-first).
- Undefined: a same-cycle, same-address read returns the full old word (read-first).
- In both cases the array is updated identically.

## Structure
- Package `sram_mask_pkg` holds:
  - FSM state enum (`INIT`, `IDLE`).
  - Lane-width helper function.
  - Localparam `DEPTH` derivation.
- Sub-module `sram_mask_lane_merge`: a combinational function of old word, new data and mask producing the merged word. It is used by the write path and by the bypass path.
- The top module owns the FSM, clear counter, storage array and read pipeline.

## Test plan
- Reset release with `ADDR_WIDTH`=4 -> `ready` rises after exactly 16 cycles. Reads of all addresses return 0.
- Write addr 5, data 0xDEADBEEFCAFEBABE, mask 0xFF. Then write addr 5, data 0x1111111111111111, mask 0x0F. Read addr 5 -> 0xDEADBEEF11111111 with `rvalid` high for one cycle.
- Same-cycle write addr 3 data 0xAAAA…AA mask 0xF0, read addr 3 (previous contents 0) -> 0xAAAAAAAA00000000 with `SRAM_MASK_BYPASS_EN`; 0 without it.
- `READ_LATENCY`=2 with reads to addrs 0,1,2 on consecutive cycles -> three consecutive `rvalid` pulses in order, the first two cycles after the first accept.
- `wce`/`rce` asserted during `INIT` -> no array change and no `rvalid`. Addr targeted by that write reads 0 after `ready`.
- `rstb` pulsed low mid-`INIT` (counter=7) and again with a read in flight -> `rvalid` drops to 0, no stale result appears, and the clear restarts and takes the full 2^`ADDR_WIDTH` cycles.
